// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: request/busy/grant bundle between bus clients and the shared-bus arbiter.
interface bus_arbiter_rr_if #(parameter int NUM_REQ = 6);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] in_reqcyc;
  logic [NUM_REQ-1:0] in_busy;
  logic [NUM_REQ-1:0] out_grant;
  logic [ID_W-1:0] out_grant_id;
  logic out_bus_busy;
  logic out_timeout;
  modport master (
    input in_reqcyc, in_busy,
    output out_grant, out_grant_id, out_bus_busy, out_timeout
  );
  modport slave (
    output in_reqcyc, in_busy,
    input out_grant, out_grant_id, out_bus_busy, out_timeout
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-way round-robin/fixed-priority shared-bus arbiter with hold and turnaround.
// Optional hold-timeout watchdog is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
  parameter int NUM_REQ = 6,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_HOLD = 256
) (
  input logic clk,
  input logic reset,
  bus_arbiter_rr_if.master bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;
  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("bus_arbiter_rr: unsupported NUM_REQ or MAX_HOLD");
  end
  state_t state;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] id, rr_ptr, nxt_id;
  logic own_req, own_busy, holding, expired, timeout;
  function automatic logic [ID_W-1:0] pick(input logic [NUM_REQ-1:0] req, input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] r;
    int j;
    r = '0;
    if (PRIORITY_MODE == 1) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) r = ID_W'(i);
    end else begin
      for (int i = NUM_REQ; i >= 1; i--) begin
        j = int'(ptr) + i;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (req[j]) r = ID_W'(j);
      end
    end
    return r;
  endfunction
  assign own_req = bus.in_reqcyc[id];
  assign own_busy = bus.in_busy[id];
  assign holding = state == GRANT || state == BUSY;
  // RELEASE re-arbitrates against the just-released owner so the next grant lands after one dead cycle
  always_comb nxt_id = pick(bus.in_reqcyc, state == RELEASE ? id : rr_ptr);
`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt;
  assign expired = holding && hold_cnt == CNT_W'(MAX_HOLD - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= holding ? hold_cnt + 1'b1 : '0;
      timeout <= expired;
    end
`else
  assign expired = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      id <= '0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (state == RELEASE) rr_ptr <= id;
          grant <= |bus.in_reqcyc ? NUM_REQ'(1) << nxt_id : '0;
          id <= |bus.in_reqcyc ? nxt_id : '0;
          state <= |bus.in_reqcyc ? GRANT : IDLE;
        end
        default: begin
          if (expired || (!own_busy && (state == BUSY || !own_req))) begin
            state <= RELEASE;
            grant <= '0;
          end else if (own_busy) state <= BUSY;
        end
      endcase
    end
  assign bus.out_grant = grant;
  assign bus.out_grant_id = id;
  assign bus.out_bus_busy = state != IDLE;
  assign bus.out_timeout = timeout;
endmodule
